iigs_ce_gen: RTL

- Parametrised multi-channel clock-enable generator driven from clk_sys.
- Each channel is a fractional-N phase accumulator. It emits single-cycle enable pulses at rate inc/2^ACC_W × f(clk_sys).
- Drives pixel, CPU fast/slow and peripheral enables in the IIgs top. Replaces the fixed divide-by-2 pixel enable.
- Rates are reprogrammed at runtime through double-buffered config registers. An external sync re-aligns all channel phases.

---
 rtl/iigs_ce_gen_if.sv | 23 ++
 rtl/iigs_ce_gen.sv | 116 +++++++++++
 2 files changed

// File: rtl/iigs_ce_gen_if.sv
// Configuration bus for iigs_ce_gen: shadow increment writes and the apply handshake.
interface iigs_ce_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_we;
  logic [CH_W-1:0] cfg_ch;
  logic [ACC_W:0]  cfg_inc;
  logic            cfg_apply;
  logic            apply_ack;

  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_apply,
    input  apply_ack
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_apply,
    output apply_ack
  );
endinterface

// File: rtl/iigs_ce_gen.sv
// Multi-channel fractional-N clock-enable generator (phase accumulator per channel).
// Optional per-channel pulse counters are enabled by defining IIGS_CE_COUNT_EN.
module iigs_ce_gen #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 16,
  parameter logic [NUM_CH*(ACC_W+1)-1:0] INC_INIT = {NUM_CH{17'h08000}},
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  iigs_ce_gen_if.slave      cfg,
  input  logic              sync_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] ce_out
`ifdef IIGS_CE_COUNT_EN
  ,
  input  logic [CH_W-1:0]   cnt_sel,
  input  logic              cnt_clr,
  output logic [15:0]       cnt_out
`endif
);

  localparam logic [ACC_W:0] INC_MAX = {1'b1, {ACC_W{1'b0}}};

  logic [ACC_W-1:0]  acc_q    [NUM_CH];
  logic [ACC_W:0]    shadow_q [NUM_CH];
  logic [ACC_W:0]    shadow_d [NUM_CH];
  logic [ACC_W:0]    active_q [NUM_CH];
  logic [ACC_W:0]    sum_c    [NUM_CH];
  logic [NUM_CH-1:0] ce_q;
  logic              apply_ack_q;
  logic              sync_q;
  logic              sync_pulse_q;
  logic [ACC_W:0]    inc_clamped;

  assign inc_clamped = (cfg.cfg_inc > INC_MAX) ? INC_MAX : cfg.cfg_inc;

  // Shadow next-state feeds both the shadow and the active set, so a write
  // landing in the same cycle as an apply is carried through.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (cfg.cfg_we && (32'(cfg.cfg_ch) < NUM_CH)) begin
      shadow_d[cfg.cfg_ch] = inc_clamped;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum_c[i] = {1'b0, acc_q[i]} + active_q[i];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i]    <= '0;
        shadow_q[i] <= INC_INIT[i*(ACC_W+1) +: (ACC_W+1)];
        active_q[i] <= INC_INIT[i*(ACC_W+1) +: (ACC_W+1)];
      end
      ce_q         <= '0;
      apply_ack_q  <= 1'b0;
      sync_q       <= 1'b0;
      sync_pulse_q <= 1'b0;
    end else begin
      sync_q       <= sync_in;
      sync_pulse_q <= sync_in & ~sync_q;
      apply_ack_q  <= cfg.cfg_apply;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (cfg.cfg_apply) begin
          active_q[i] <= shadow_d[i];
        end
        if (sync_pulse_q) begin
          acc_q[i] <= '0;
          ce_q[i]  <= 1'b0;
        end else if (ch_en[i]) begin
          acc_q[i] <= sum_c[i][ACC_W-1:0];
          ce_q[i]  <= sum_c[i][ACC_W];
        end else begin
          ce_q[i]  <= 1'b0;
        end
      end
    end
  end

  assign ce_out        = ce_q;
  assign cfg.apply_ack = apply_ack_q;

`ifdef IIGS_CE_COUNT_EN
  logic [15:0] cnt_q [NUM_CH];
  logic [15:0] cnt_out_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_out_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cnt_clr || sync_pulse_q) begin
          cnt_q[i] <= '0;
        end else if (ce_q[i]) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
      cnt_out_q <= (32'(cnt_sel) < NUM_CH) ? cnt_q[cnt_sel] : '0;
    end
  end

  assign cnt_out = cnt_out_q;
`endif

endmodule
